// File: rtl/sn_pingpong_buf.sv
// Two-bank ping-pong packet buffer between the stream snooper (writer) and a
// packet consumer (reader); banks are filled and drained strictly in order.
module sn_pingpong_buf #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned INC_WIDTH  = 3,
  parameter int unsigned LEN_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] sn_addr,
  input  logic [DATA_WIDTH-1:0] sn_wr_data,
  input  logic                  sn_wr_en,
  input  logic [INC_WIDTH-1:0]  sn_byte_inc,
  input  logic                  sn_done,
  output logic                  rdy_for_sn,
  input  logic                  rdy_for_sn_ack,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  pkt_rdy,
  output logic [LEN_WIDTH-1:0]  pkt_len,
  input  logic                  rd_done
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned DEPTH = 2 ** (ADDR_WIDTH + 1);

  typedef enum logic [1:0] {FREE, FILLING, FULL, READING} bank_state_t;

  bank_state_t           bank_q [2];
  bank_state_t           bank_d [2];
  logic [LEN_WIDTH-1:0]  len_q  [2];
  logic [LEN_WIDTH-1:0]  len_d  [2];
  logic                  wr_sel, wr_sel_d;
  logic                  rd_sel, rd_sel_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  filling, claim, wr_fire, done_fire, rd_fire, release_fire;
  logic [LEN_WIDTH:0]    inc_ext, len_sum;
  logic [LEN_WIDTH-1:0]  len_sat;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      bank_q[0] <= FREE;
      bank_q[1] <= FREE;
      len_q[0]  <= '0;
      len_q[1]  <= '0;
      wr_sel    <= '0;
      rd_sel    <= '0;
      rd_data   <= '0;
      rd_valid  <= '0;
    end else begin
      bank_q[0] <= bank_d[0];
      bank_q[1] <= bank_d[1];
      len_q[0]  <= len_d[0];
      len_q[1]  <= len_d[1];
      wr_sel    <= wr_sel_d;
      rd_sel    <= rd_sel_d;
      rd_valid  <= rd_fire;
      if (rd_fire) rd_data <= mem[{rd_sel, rd_addr}];
    end
  end

  // Packet RAM is never cleared; the bank select forms the address MSB.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[{wr_sel, sn_addr}] <= sn_wr_data;
  end

  // Outputs and handshake qualifiers
  always_comb begin
    rdy_for_sn   = rst && (bank_q[wr_sel] == FREE);
    pkt_rdy      = (bank_q[rd_sel] == FULL) || (bank_q[rd_sel] == READING);
    pkt_len      = pkt_rdy ? len_q[rd_sel] : '0;
    filling      = bank_q[wr_sel] == FILLING;
    claim        = rdy_for_sn && rdy_for_sn_ack;
    wr_fire      = rst && filling && sn_wr_en;
    done_fire    = filling && sn_done;
    rd_fire      = rd_en && pkt_rdy;
    release_fire = rd_done && pkt_rdy;
  end

  always_comb begin
    inc_ext = (sn_byte_inc == '0) ? (LEN_WIDTH + 1)'(BYTES) : (LEN_WIDTH + 1)'(sn_byte_inc);
    len_sum = {1'b0, len_q[wr_sel]} + inc_ext;
    len_sat = len_sum[LEN_WIDTH] ? '1 : len_sum[LEN_WIDTH-1:0];
  end

  // Next state; writer and reader act on different banks, so both may fire together.
  always_comb begin
    bank_d[0] = bank_q[0];
    bank_d[1] = bank_q[1];
    len_d[0]  = len_q[0];
    len_d[1]  = len_q[1];
    wr_sel_d  = wr_sel;
    rd_sel_d  = rd_sel;
    if (claim) begin
      bank_d[wr_sel] = FILLING;
      len_d[wr_sel]  = '0;
    end
    if (wr_fire) len_d[wr_sel] = len_sat;
    if (done_fire) begin
      bank_d[wr_sel] = FULL;
      wr_sel_d       = ~wr_sel;
    end
    if (rd_fire && bank_q[rd_sel] == FULL) bank_d[rd_sel] = READING;
    if (release_fire) begin
      bank_d[rd_sel] = FREE;
      rd_sel_d       = ~rd_sel;
    end
  end

endmodule

// File: tb/tb_sn_pingpong_buf.sv
// Self-checking bench for sn_pingpong_buf: directed scenarios plus randomized
// packets compared against a bank-level packet model.
module tb_sn_pingpong_buf;
  localparam int DW = 64;
  localparam int AW = 9;
  localparam int IW = 3;
  localparam int LW = 12;
  localparam int MAXLEN = 4095;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] sn_addr = '0;
  logic [DW-1:0] sn_wr_data = '0;
  logic          sn_wr_en = 1'b0;
  logic [IW-1:0] sn_byte_inc = '0;
  logic          sn_done = 1'b0;
  logic          rdy_for_sn;
  logic          rdy_for_sn_ack = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          pkt_rdy;
  logic [LW-1:0] pkt_len;
  logic          rd_done = 1'b0;

  sn_pingpong_buf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INC_WIDTH(IW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .sn_addr(sn_addr), .sn_wr_data(sn_wr_data), .sn_wr_en(sn_wr_en),
    .sn_byte_inc(sn_byte_inc), .sn_done(sn_done), .rdy_for_sn(rdy_for_sn),
    .rdy_for_sn_ack(rdy_for_sn_ack), .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
    .rd_valid(rd_valid), .pkt_rdy(pkt_rdy), .pkt_len(pkt_len), .rd_done(rd_done)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Model: per-bank word images, packet lengths in fill order, alternating banks.
  logic [DW-1:0] ref_mem [2][512];
  int unsigned   pq[$];
  int unsigned   m_wr, m_rd, cur_len, cur_words;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sn_wr_en = 1'b0; sn_done = 1'b0; rdy_for_sn_ack = 1'b0;
    rd_en = 1'b0; rd_done = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    step();
    rst = 1'b1;
    #1;
    m_wr = 0; m_rd = 0; cur_len = 0;
    pq.delete();
  endtask

  task automatic claim();
    rdy_for_sn_ack = 1'b1;
    step();
    rdy_for_sn_ack = 1'b0;
    cur_len = 0;
    cur_words = 0;
  endtask

  task automatic wr(input int unsigned addr, input logic [DW-1:0] data,
                    input int unsigned inc, input bit done);
    sn_addr = AW'(addr); sn_wr_data = data; sn_byte_inc = IW'(inc);
    sn_wr_en = 1'b1; sn_done = done;
    step();
    sn_wr_en = 1'b0; sn_done = 1'b0;
    ref_mem[m_wr][addr] = data;
    cur_len += (inc == 0) ? 8 : inc;
    if (cur_len > MAXLEN) cur_len = MAXLEN;
    cur_words++;
    if (done) begin
      pq.push_back(cur_len);
      m_wr ^= 1;
    end
  endtask

  task automatic done_only();
    sn_done = 1'b1;
    step();
    sn_done = 1'b0;
    pq.push_back(cur_len);
    m_wr ^= 1;
  endtask

  task automatic release_pkt();
    rd_done = 1'b1;
    step();
    rd_done = 1'b0;
    void'(pq.pop_front());
    m_rd ^= 1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    step();
    checks++;
    if (rdy_for_sn !== 1'b0 || pkt_rdy !== 1'b0 || pkt_len !== '0 || rd_data !== '0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b pkt_rdy=%b len=%0d data=%h valid=%b, required 0 0 0 0 0",
               rdy_for_sn, pkt_rdy, pkt_len, rd_data, rd_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (rdy_for_sn !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_rdy: got %b required 1", rdy_for_sn);
    end
    m_wr = 0; m_rd = 0; pq.delete();
  endtask

  task automatic test_single_packet();
    do_reset();
    step();
    claim();
    checks++;
    if (rdy_for_sn !== 1'b0) begin
      errors++;
      $display("FAIL claim_drops_rdy: got %b required 0", rdy_for_sn);
    end
    wr(0, {$urandom, $urandom}, 0, 0);
    wr(1, {$urandom, $urandom}, 0, 0);
    wr(2, {$urandom, $urandom}, 5, 0);
    checks++;
    if (pkt_rdy !== 1'b0) begin
      errors++;
      $display("FAIL no_pkt_while_filling: got %b required 0", pkt_rdy);
    end
    done_only();
    checks++;
    if (pkt_rdy !== 1'b1 || pkt_len !== LW'(21) || pkt_len !== LW'(pq[0])) begin
      errors++;
      $display("FAIL single_len: pkt_rdy=%b len=%0d required 1 21", pkt_rdy, pkt_len);
    end
    for (int a = 0; a < 3; a++) begin
      rd_addr = AW'(a); rd_en = 1'b1;
      step();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== ref_mem[m_rd][a]) begin
        errors++;
        $display("FAIL single_read[%0d]: valid=%b data=%h required 1 %h", a, rd_valid, rd_data, ref_mem[m_rd][a]);
      end
    end
    rd_en = 1'b0;
    step();
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL valid_drops: got %b required 0", rd_valid);
    end
    release_pkt();
  endtask

  task automatic test_write_done_same();
    logic [DW-1:0] d;
    d = {$urandom, $urandom};
    claim();
    wr(7, d, 3, 1);
    checks++;
    if (pkt_rdy !== 1'b1 || pkt_len !== LW'(3)) begin
      errors++;
      $display("FAIL wr_done_len: pkt_rdy=%b len=%0d required 1 3", pkt_rdy, pkt_len);
    end
    rd_addr = AW'(7); rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== d) begin
      errors++;
      $display("FAIL wr_done_data: valid=%b data=%h required 1 %h", rd_valid, rd_data, d);
    end
    release_pkt();
  endtask

  task automatic test_ping_pong();
    logic [DW-1:0] a0;
    do_reset();
    claim();
    wr(0, {$urandom, $urandom}, 0, 1);
    a0 = ref_mem[0][0];
    checks++;
    if (rdy_for_sn !== 1'b1) begin
      errors++;
      $display("FAIL pp_second_free: got %b required 1", rdy_for_sn);
    end
    claim();
    wr(0, {$urandom, $urandom}, 0, 0);
    wr(1, {$urandom, $urandom}, 0, 1);
    checks++;
    if (rdy_for_sn !== 1'b0 || pkt_len !== LW'(8) || pkt_len !== LW'(pq[0])) begin
      errors++;
      $display("FAIL pp_both_full: rdy=%b len=%0d required 0 8", rdy_for_sn, pkt_len);
    end
    // Ack while both banks are full must be ignored.
    rdy_for_sn_ack = 1'b1;
    step();
    rdy_for_sn_ack = 1'b0;
    // Read in the same cycle as the release still returns A's data.
    rd_addr = '0; rd_en = 1'b1; rd_done = 1'b1;
    step();
    rd_en = 1'b0; rd_done = 1'b0;
    void'(pq.pop_front());
    m_rd ^= 1;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== a0) begin
      errors++;
      $display("FAIL pp_read_at_release: valid=%b data=%h required 1 %h", rd_valid, rd_data, a0);
    end
    checks++;
    if (pkt_rdy !== 1'b1 || pkt_len !== LW'(16) || rdy_for_sn !== 1'b1) begin
      errors++;
      $display("FAIL pp_switch: pkt_rdy=%b len=%0d rdy=%b required 1 16 1", pkt_rdy, pkt_len, rdy_for_sn);
    end
    for (int a = 0; a < 2; a++) begin
      rd_addr = AW'(a); rd_en = 1'b1;
      step();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== ref_mem[m_rd][a]) begin
        errors++;
        $display("FAIL pp_read_b[%0d]: valid=%b data=%h required 1 %h", a, rd_valid, rd_data, ref_mem[m_rd][a]);
      end
    end
    rd_en = 1'b0;
    // Claim bank 0 while releasing bank 1 in the same cycle.
    rdy_for_sn_ack = 1'b1; rd_done = 1'b1;
    step();
    rdy_for_sn_ack = 1'b0; rd_done = 1'b0;
    void'(pq.pop_front());
    m_rd ^= 1;
    cur_len = 0;
    checks++;
    if (rdy_for_sn !== 1'b0 || pkt_rdy !== 1'b0 || pkt_len !== '0) begin
      errors++;
      $display("FAIL pp_claim_and_release: rdy=%b pkt_rdy=%b len=%0d required 0 0 0", rdy_for_sn, pkt_rdy, pkt_len);
    end
    wr(4, {$urandom, $urandom}, 6, 1);
    checks++;
    if (pkt_rdy !== 1'b1 || pkt_len !== LW'(6) || rdy_for_sn !== 1'b1) begin
      errors++;
      $display("FAIL pp_after_dual: pkt_rdy=%b len=%0d rdy=%b required 1 6 1", pkt_rdy, pkt_len, rdy_for_sn);
    end
    release_pkt();
  endtask

  task automatic test_saturation();
    do_reset();
    claim();
    for (int i = 0; i < 600; i++) wr(i % 512, {$urandom, $urandom}, 0, (i == 599));
    checks++;
    if (pkt_len !== LW'(MAXLEN) || pkt_len !== LW'(pq[0])) begin
      errors++;
      $display("FAIL saturation: len=%0d required %0d", pkt_len, MAXLEN);
    end
    rd_addr = AW'(87); rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    checks++;
    if (rd_data !== ref_mem[0][87]) begin
      errors++;
      $display("FAIL saturation_wrap_data: got %h required %h", rd_data, ref_mem[0][87]);
    end
    release_pkt();
  endtask

  task automatic test_spurious();
    logic [DW-1:0] d;
    do_reset();
    sn_addr = AW'(5); sn_wr_data = {$urandom, $urandom}; sn_byte_inc = IW'(3);
    sn_wr_en = 1'b1; sn_done = 1'b1;
    step();
    idle();
    rd_done = 1'b1; rd_en = 1'b1; rd_addr = AW'(5);
    step();
    idle();
    checks++;
    if (rd_valid !== 1'b0 || pkt_rdy !== 1'b0 || pkt_len !== '0 || rd_data !== '0 || rdy_for_sn !== 1'b1) begin
      errors++;
      $display("FAIL spurious: valid=%b pkt_rdy=%b len=%0d data=%h rdy=%b required 0 0 0 0 1",
               rd_valid, pkt_rdy, pkt_len, rd_data, rdy_for_sn);
    end
    d = {$urandom, $urandom};
    claim();
    wr(5, d, 2, 1);
    rd_addr = AW'(5); rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    checks++;
    if (pkt_len !== LW'(2) || rd_data !== d) begin
      errors++;
      $display("FAIL spurious_followup: len=%0d data=%h required 2 %h", pkt_len, rd_data, d);
    end
    release_pkt();
  endtask

  task automatic test_reset_mid_fill();
    logic [DW-1:0] d;
    do_reset();
    claim();
    wr(0, {$urandom, $urandom}, 0, 1);
    claim();
    wr(0, {$urandom, $urandom}, 0, 0);
    wr(1, {$urandom, $urandom}, 0, 0);
    rst = 1'b0;
    step();
    checks++;
    if (pkt_rdy !== 1'b0 || rdy_for_sn !== 1'b0 || pkt_len !== '0) begin
      errors++;
      $display("FAIL midfill_reset: pkt_rdy=%b rdy=%b len=%0d required 0 0 0", pkt_rdy, rdy_for_sn, pkt_len);
    end
    rst = 1'b1;
    #1;
    m_wr = 0; m_rd = 0; pq.delete();
    checks++;
    if (rdy_for_sn !== 1'b1) begin
      errors++;
      $display("FAIL midfill_release_rdy: got %b required 1", rdy_for_sn);
    end
    d = {$urandom, $urandom};
    claim();
    wr(3, d, 1, 1);
    rd_addr = AW'(3); rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    checks++;
    if (pkt_rdy !== 1'b1 || pkt_len !== LW'(1) || rd_data !== d || rdy_for_sn !== 1'b1) begin
      errors++;
      $display("FAIL midfill_wr_sel0: pkt_rdy=%b len=%0d data=%h rdy=%b required 1 1 %h 1",
               pkt_rdy, pkt_len, rd_data, rdy_for_sn, d);
    end
    release_pkt();
  endtask

  task automatic test_random();
    int unsigned nw [2];
    do_reset();
    for (int p = 0; p < 12; p++) begin
      for (int k = 0; k < 2; k++) begin
        claim();
        nw[k] = $urandom_range(1, 8);
        for (int w = 0; w < int'(nw[k]); w++)
          wr(w, {$urandom, $urandom}, $urandom_range(0, 7), (w == int'(nw[k]) - 1));
      end
      checks++;
      if (rdy_for_sn !== 1'b0) begin
        errors++;
        $display("FAIL rand_full[%0d]: rdy=%b required 0", p, rdy_for_sn);
      end
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (pkt_rdy !== 1'b1 || pkt_len !== LW'(pq[0])) begin
          errors++;
          $display("FAIL rand_len[%0d.%0d]: pkt_rdy=%b len=%0d required 1 %0d", p, k, pkt_rdy, pkt_len, pq[0]);
        end
        for (int w = 0; w < int'(nw[k]); w++) begin
          rd_addr = AW'(w); rd_en = 1'b1;
          step();
          checks++;
          if (rd_valid !== 1'b1 || rd_data !== ref_mem[m_rd][w]) begin
            errors++;
            $display("FAIL rand_read[%0d.%0d.%0d]: valid=%b data=%h required 1 %h",
                     p, k, w, rd_valid, rd_data, ref_mem[m_rd][w]);
          end
        end
        rd_en = 1'b0;
        release_pkt();
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_write_done_same();
    test_ping_pong();
    test_saturation();
    test_spurious();
    test_reset_mid_fill();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
